// File: rtl/fft_pkg.sv
// ---------------------------------------------------------------------------
// fft_pkg
// Shared constants and state encoding for the 64-point FFT loader/unloader.
//   N_POINTS : samples per frame (power of two)
//   ADDR_W   : log2(N_POINTS), width of buffer addresses and frame counters
//   DATA_W   : width of each real / imaginary component
//   ld_state_e : loader FSM encoding (LOAD -> LAUNCH -> BUSY -> LOAD)
// ---------------------------------------------------------------------------
package fft_pkg;

  localparam int N_POINTS = 64;
  localparam int ADDR_W   = 6;
  localparam int DATA_W   = 16;

  typedef enum logic [1:0] {
    ST_LOAD   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_BUSY   = 2'd2
  } ld_state_e;

endpackage

// File: rtl/bit_reverse.sv
// ---------------------------------------------------------------------------
// bit_reverse
// Purely combinational bit-order reversal of an ADDR_W-bit address, used to
// produce the bit-reversed buffer ordering the FFT core expects.
// Ports:
//   in_i  [ADDR_W-1:0] : natural-order value
//   out_o [ADDR_W-1:0] : value with bit i moved to bit ADDR_W-1-i
// ---------------------------------------------------------------------------
module bit_reverse #(
  parameter int ADDR_W = 6
) (
  input  logic [ADDR_W-1:0] in_i,
  output logic [ADDR_W-1:0] out_o
);

  genvar gi;
  generate
    for (gi = 0; gi < ADDR_W; gi++) begin : g_rev
      assign out_o[gi] = in_i[ADDR_W-1-gi];
    end
  endgenerate

endmodule

// File: rtl/input_counter.sv
// ---------------------------------------------------------------------------
// input_counter
// Input-side loader for the FFT core. Accepts one frame of N_POINTS complex
// samples over a valid/ready handshake, writes each into the core's input
// buffer (natural or bit-reversed address), pulses start once the frame is
// complete, then refuses data until the core signals core_done.
// Ports:
//   clk, rst           : clock (rising edge), asynchronous active-low reset
//   din_valid/re/im    : upstream sample and its valid
//   din_ready          : high while loading (decoded from state only)
//   wr_en/addr/re/im   : registered input-buffer write, one cycle after transfer
//   start              : one-cycle pulse, frame loaded
//   core_done          : one-cycle pulse from core, buffer free again
//   counter_o          : samples accepted so far in the current frame
// ---------------------------------------------------------------------------
module input_counter #(
  parameter int N_POINTS = fft_pkg::N_POINTS,
  parameter int ADDR_W   = fft_pkg::ADDR_W,
  parameter int DATA_W   = fft_pkg::DATA_W,
  parameter int BITREV   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              din_valid,
  input  logic [DATA_W-1:0] din_re,
  input  logic [DATA_W-1:0] din_im,
  output logic              din_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_re,
  output logic [DATA_W-1:0] wr_im,
  output logic              start,
  input  logic              core_done,
  output logic [ADDR_W-1:0] counter_o
);

  import fft_pkg::*;

  localparam logic [ADDR_W-1:0] LAST_CNT = ADDR_W'(N_POINTS - 1);

  ld_state_e         state_q, state_d;
  logic [ADDR_W-1:0] counter_q, counter_d;
  logic              start_q, start_d;
  logic              wr_en_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [DATA_W-1:0] wr_re_q, wr_im_q;
  logic [ADDR_W-1:0] rev_addr;
  logic [ADDR_W-1:0] addr_sel;
  logic              xfer;

  // Ready depends on state only so upstream never sees a valid->ready loop.
  assign din_ready = (state_q == ST_LOAD);
  assign xfer      = din_valid & din_ready;

  bit_reverse #(
    .ADDR_W (ADDR_W)
  ) u_bit_reverse (
    .in_i  (counter_q),
    .out_o (rev_addr)
  );

  // The address comes from the pre-increment count of this transfer.
  assign addr_sel = (BITREV != 0) ? rev_addr : counter_q;

  always_comb begin
    state_d   = state_q;
    counter_d = counter_q;
    start_d   = 1'b0;
    case (state_q)
      ST_LOAD: begin
        if (xfer) begin
          // Natural ADDR_W-bit wrap takes N_POINTS-1 back to 0.
          counter_d = counter_q + 1'b1;
          if (counter_q == LAST_CNT) begin
            state_d = ST_LAUNCH;
          end
        end
      end
      ST_LAUNCH: begin
        // One dead cycle lets the final buffer write land before start.
        state_d = ST_BUSY;
        start_d = 1'b1;
      end
      ST_BUSY: begin
        if (core_done) begin
          state_d = ST_LOAD;
        end
      end
      default: begin
        state_d = ST_LOAD;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_LOAD;
      counter_q <= '0;
      start_q   <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_re_q   <= '0;
      wr_im_q   <= '0;
    end else begin
      state_q   <= state_d;
      counter_q <= counter_d;
      start_q   <= start_d;
      wr_en_q   <= xfer;
      if (xfer) begin
        wr_addr_q <= addr_sel;
        wr_re_q   <= din_re;
        wr_im_q   <= din_im;
      end
    end
  end

  assign wr_en     = wr_en_q;
  assign wr_addr   = wr_addr_q;
  assign wr_re     = wr_re_q;
  assign wr_im     = wr_im_q;
  assign start     = start_q;
  assign counter_o = counter_q;

endmodule

// File: tb/tb_input_counter.sv
module tb_input_counter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        din_valid = 1'b0;
  logic [15:0] din_re = '0;
  logic [15:0] din_im = '0;
  logic        core_done = 1'b0;

  logic        rdy_a, wen_a, st_a;
  logic [5:0]  addr_a, cnt_a;
  logic [15:0] re_a, im_a;
  logic        rdy_b, wen_b, st_b;
  logic [5:0]  addr_b, cnt_b;
  logic [15:0] re_b, im_b;

  int tests  = 0;
  int errors = 0;
  int seen[64];
  int next_idx = 0;

  always #5 clk = ~clk;

  // Bit-reversed instance
  input_counter #(.N_POINTS(64), .ADDR_W(6), .DATA_W(16), .BITREV(1)) u_rev (
    .clk(clk), .rst(rst), .din_valid(din_valid), .din_re(din_re), .din_im(din_im),
    .din_ready(rdy_a), .wr_en(wen_a), .wr_addr(addr_a), .wr_re(re_a), .wr_im(im_a),
    .start(st_a), .core_done(core_done), .counter_o(cnt_a));

  // Natural-order instance, same stimulus
  input_counter #(.N_POINTS(64), .ADDR_W(6), .DATA_W(16), .BITREV(0)) u_nat (
    .clk(clk), .rst(rst), .din_valid(din_valid), .din_re(din_re), .din_im(din_im),
    .din_ready(rdy_b), .wr_en(wen_b), .wr_addr(addr_b), .wr_re(re_b), .wr_im(im_b),
    .start(st_b), .core_done(core_done), .counter_o(cnt_b));

  function automatic logic [5:0] rev6(input int v);
    logic [5:0] x;
    logic [5:0] r;
    x = 6'(v);
    for (int k = 0; k < 6; k++) r[k] = x[5-k];
    return r;
  endfunction

  task automatic clear_seen();
    for (int k = 0; k < 64; k++) seen[k] = 0;
  endtask

  task automatic drive_sample(input int idx);
    din_valid = 1'b1;
    din_re    = 16'(idx);
    din_im    = ~16'(idx);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    din_valid = 1'b1;
    din_re = 16'h1234;
    din_im = 16'h5678;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      tests++;
      if ({rdy_a, wen_a, st_a, rdy_b, wen_b, st_b} !== 6'b100100) begin
        errors++;
        $display("FAIL reset_ctrl: ready/wr_en/start a,b = %b%b%b %b%b%b, need 100 100",
                 rdy_a, wen_a, st_a, rdy_b, wen_b, st_b);
      end
      tests++;
      if ({addr_a, cnt_a, re_a, im_a} !== 44'd0) begin
        errors++;
        $display("FAIL reset_data: addr=%0d cnt=%0d re=%h im=%h, need all 0",
                 addr_a, cnt_a, re_a, im_a);
      end
    end
    din_valid = 1'b0;
    rst = 1'b1;
    next_idx = 0;
    clear_seen();
  endtask

  task automatic test_back_to_back();
    int bad;
    for (int i = 0; i < 64; i++) begin
      tests++;
      if (rdy_a !== 1'b1) begin
        errors++;
        $display("FAIL b2b_ready idx %0d: din_ready=%b, need 1", i, rdy_a);
      end
      drive_sample(i);
      @(negedge clk);
      tests++;
      if (wen_a !== 1'b1 || wen_b !== 1'b1 || addr_a !== rev6(i) || addr_b !== 6'(i) ||
          re_a !== 16'(i) || im_a !== ~16'(i) || cnt_a !== 6'((i + 1) % 64) || st_a !== 1'b0) begin
        errors++;
        $display("FAIL b2b_write idx %0d: wen=%b%b addr=%0d/%0d re=%h im=%h cnt=%0d start=%b, need 11 %0d/%0d %h %h %0d 0",
                 i, wen_a, wen_b, addr_a, addr_b, re_a, im_a, cnt_a, st_a,
                 rev6(i), i, 16'(i), ~16'(i), (i + 1) % 64);
      end
      if (wen_a === 1'b1) seen[addr_a]++;
      if (i == 5) begin
        tests++;
        if (addr_a !== 6'd40) begin
          errors++;
          $display("FAIL b2b_idx5_addr: got %0d, need 40", addr_a);
        end
      end
      if (i == 1) begin
        tests++;
        if (addr_a !== 6'd32) begin
          errors++;
          $display("FAIL b2b_idx1_addr: got %0d, need 32", addr_a);
        end
      end
    end
    // Now in LAUNCH; keep valid high to prove nothing is accepted.
    din_re = 16'hDEAD;
    tests++;
    if (rdy_a !== 1'b0 || rdy_b !== 1'b0 || st_a !== 1'b0) begin
      errors++;
      $display("FAIL b2b_launch: ready=%b%b start=%b, need 00 0", rdy_a, rdy_b, st_a);
    end
    @(negedge clk);
    tests++;
    if (st_a !== 1'b1 || st_b !== 1'b1 || wen_a !== 1'b0 || rdy_a !== 1'b0) begin
      errors++;
      $display("FAIL b2b_start: start=%b%b wen=%b ready=%b, need 11 0 0", st_a, st_b, wen_a, rdy_a);
    end
    @(negedge clk);
    tests++;
    if (st_a !== 1'b0 || st_b !== 1'b0) begin
      errors++;
      $display("FAIL b2b_start_width: start=%b%b one cycle later, need 00", st_a, st_b);
    end
    bad = 0;
    for (int k = 0; k < 64; k++) if (seen[k] != 1) bad++;
    tests++;
    if (bad != 0) begin
      errors++;
      $display("FAIL b2b_coverage: %0d addresses not written exactly once, need 0", bad);
    end
  endtask

  task automatic test_busy_hold();
    din_valid = 1'b1;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      tests++;
      if (wen_a !== 1'b0 || wen_b !== 1'b0 || rdy_a !== 1'b0 || st_a !== 1'b0) begin
        errors++;
        $display("FAIL busy_hold cycle %0d: wen=%b%b ready=%b start=%b, need 00 0 0",
                 c, wen_a, wen_b, rdy_a, st_a);
      end
    end
    clear_seen();
    drive_sample(0);
    core_done = 1'b1;
    @(negedge clk);
    core_done = 1'b0;
    tests++;
    if (rdy_a !== 1'b1 || wen_a !== 1'b0 || cnt_a !== 6'd0) begin
      errors++;
      $display("FAIL busy_release: ready=%b wen=%b cnt=%0d, need 1 0 0", rdy_a, wen_a, cnt_a);
    end
    @(negedge clk);
    tests++;
    if (wen_a !== 1'b1 || addr_a !== 6'd0 || re_a !== 16'd0 || cnt_a !== 6'd1) begin
      errors++;
      $display("FAIL busy_first_xfer: wen=%b addr=%0d re=%h cnt=%0d, need 1 0 0000 1",
               wen_a, addr_a, re_a, cnt_a);
    end
    if (wen_a === 1'b1) seen[addr_a]++;
    din_valid = 1'b0;
    next_idx = 1;
  endtask

  task automatic test_core_done_load();
    for (int i = 1; i < 20; i++) begin
      if (i == 10) begin
        tests++;
        if (cnt_a !== 6'd10) begin
          errors++;
          $display("FAIL cdl_count: cnt=%0d, need 10", cnt_a);
        end
        din_valid = 1'b0;
        core_done = 1'b1;
        @(negedge clk);
        core_done = 1'b0;
        tests++;
        if (rdy_a !== 1'b1 || wen_a !== 1'b0 || cnt_a !== 6'd10 || st_a !== 1'b0) begin
          errors++;
          $display("FAIL cdl_ignored: ready=%b wen=%b cnt=%0d start=%b, need 1 0 10 0",
                   rdy_a, wen_a, cnt_a, st_a);
        end
      end
      drive_sample(i);
      @(negedge clk);
      tests++;
      if (wen_a !== 1'b1 || addr_a !== rev6(i) || re_a !== 16'(i) || cnt_a !== 6'(i + 1)) begin
        errors++;
        $display("FAIL cdl_write idx %0d: wen=%b addr=%0d re=%h cnt=%0d, need 1 %0d %h %0d",
                 i, wen_a, addr_a, re_a, cnt_a, rev6(i), 16'(i), i + 1);
      end
      if (wen_a === 1'b1) seen[addr_a]++;
    end
    din_valid = 1'b0;
    next_idx = 20;
  endtask

  task automatic test_random_valid();
    int cycles;
    int bad;
    bit v;
    cycles = 0;
    while (next_idx < 64 && cycles < 2000) begin
      v = 1'($urandom_range(0, 1));
      drive_sample(next_idx);
      din_valid = v;
      @(negedge clk);
      cycles++;
      if (v) begin
        tests++;
        if (wen_a !== 1'b1 || addr_a !== rev6(next_idx) || re_a !== 16'(next_idx)) begin
          errors++;
          $display("FAIL rnd_write idx %0d: wen=%b addr=%0d re=%h, need 1 %0d %h",
                   next_idx, wen_a, addr_a, re_a, rev6(next_idx), 16'(next_idx));
        end
        if (wen_a === 1'b1) seen[addr_a]++;
        next_idx++;
      end else begin
        tests++;
        if (wen_a !== 1'b0) begin
          errors++;
          $display("FAIL rnd_idle idx %0d: wen=%b, need 0", next_idx, wen_a);
        end
      end
      tests++;
      if (cnt_a !== 6'(next_idx % 64)) begin
        errors++;
        $display("FAIL rnd_count: cnt=%0d, need %0d", cnt_a, next_idx % 64);
      end
    end
    tests++;
    if (next_idx != 64) begin
      errors++;
      $display("FAIL rnd_timeout: only %0d samples sent, need 64", next_idx);
    end
    din_valid = 1'b0;
    tests++;
    if (rdy_a !== 1'b0 || st_a !== 1'b0) begin
      errors++;
      $display("FAIL rnd_launch: ready=%b start=%b, need 0 0", rdy_a, st_a);
    end
    @(negedge clk);
    tests++;
    if (st_a !== 1'b1 || wen_a !== 1'b0) begin
      errors++;
      $display("FAIL rnd_start: start=%b wen=%b, need 1 0", st_a, wen_a);
    end
    bad = 0;
    for (int k = 0; k < 64; k++) if (seen[k] != 1) bad++;
    tests++;
    if (bad != 0) begin
      errors++;
      $display("FAIL rnd_coverage: %0d addresses not written exactly once, need 0", bad);
    end
    core_done = 1'b1;
    @(negedge clk);
    core_done = 1'b0;
    tests++;
    if (rdy_a !== 1'b1 || cnt_a !== 6'd0) begin
      errors++;
      $display("FAIL rnd_release: ready=%b cnt=%0d, need 1 0", rdy_a, cnt_a);
    end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 30; i++) begin
      drive_sample(i);
      @(negedge clk);
    end
    tests++;
    if (cnt_a !== 6'd30 || wen_a !== 1'b1) begin
      errors++;
      $display("FAIL arst_pre: cnt=%0d wen=%b, need 30 1", cnt_a, wen_a);
    end
    #2 rst = 1'b0;
    #1;
    tests++;
    if ({wen_a, st_a, addr_a, cnt_a, re_a, im_a} !== 46'd0 || rdy_a !== 1'b1) begin
      errors++;
      $display("FAIL arst_immediate: wen=%b start=%b addr=%0d cnt=%0d re=%h im=%h ready=%b, need all 0, ready 1",
               wen_a, st_a, addr_a, cnt_a, re_a, im_a, rdy_a);
    end
    @(negedge clk);
    tests++;
    if (wen_a !== 1'b0 || cnt_a !== 6'd0) begin
      errors++;
      $display("FAIL arst_hold: wen=%b cnt=%0d with valid high in reset, need 0 0", wen_a, cnt_a);
    end
    rst = 1'b1;
    for (int i = 0; i < 64; i++) begin
      drive_sample(i);
      @(negedge clk);
      tests++;
      if (wen_a !== 1'b1 || addr_a !== rev6(i) || re_a !== 16'(i) || st_a !== 1'b0) begin
        errors++;
        $display("FAIL arst_reload idx %0d: wen=%b addr=%0d re=%h start=%b, need 1 %0d %h 0",
                 i, wen_a, addr_a, re_a, st_a, rev6(i), 16'(i));
      end
    end
    din_valid = 1'b0;
    @(negedge clk);
    tests++;
    if (st_a !== 1'b1) begin
      errors++;
      $display("FAIL arst_start: start=%b after new frame, need 1", st_a);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_back_to_back();
    test_busy_hold();
    test_core_done_load();
    test_random_valid();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
